alarm_sequencer: RTL and testbench

Alarm trigger and ring-duration controller for the world clock. Compares the running time against the programmed alarm time. On a match it asserts `start` to the ambulance melody player directly downstream, and holds it for a bounded ring period. Handles stop and snooze pushbuttons, so the player only sees a clean, glitch-free `start` level.

---
 rtl/alarm_sequencer.sv | 173 +++++++++++++++++
 tb/tb_alarm_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: compares running time with the programmed alarm, drives a
// glitch-free registered start level to the melody player and sequences
// ring / snooze / stop handling.
// Optional feature macro: ALARM_SNOOZE_EN (snooze button and SNOOZE state).
// Without it the snooze input is ignored and snz_cnt stays 0.
module alarm_sequencer #(
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_SEC = 300,
    parameter int unsigned MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic [4:0] alm_hour,
    input  logic [5:0] alm_min,
    input  logic       alm_en,
    input  logic       stop_btn,
    input  logic       snooze_btn,
    output logic       start,
    output logic [1:0] state,
    output logic [1:0] snz_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RING   = 2'b01,
        ST_SNOOZE = 2'b10
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic       start_r;
    logic [1:0] snz_r;
    logic [1:0] snz_step_s;
    logic [1:0] snz_nxt_s;
    logic [8:0] sec_r;
    logic [8:0] sec_nxt_s;
    logic       match_s;
    logic       match_d_r;
    logic       trigger_s;
    logic [2:0] stop_sync_r;   // [0],[1] synchronizer, [2] previous value
    logic       stop_p_s;
    logic       snooze_p_s;

    // Stop button: two-flop synchronizer plus a history flop for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stop_sync_r <= 3'b000;
        end else begin
            stop_sync_r <= {stop_sync_r[1:0], stop_btn};
        end
    end

    assign stop_p_s = stop_sync_r[1] & ~stop_sync_r[2];

`ifdef ALARM_SNOOZE_EN
    logic [2:0] snooze_sync_r;

    // Snooze button: two-flop synchronizer plus a history flop for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snooze_sync_r <= 3'b000;
        end else begin
            snooze_sync_r <= {snooze_sync_r[1:0], snooze_btn};
        end
    end

    assign snooze_p_s = snooze_sync_r[1] & ~snooze_sync_r[2];
`else
    logic unused_snooze_s;

    // Snooze is not built: the raw button is intentionally left unconnected
    assign unused_snooze_s = snooze_btn;
    assign snooze_p_s      = 1'b0;
`endif

    assign match_s   = alm_en & (cur_hour == alm_hour) & (cur_min == alm_min) &
                       (cur_sec == 6'd0);
    assign trigger_s = match_s & ~match_d_r;

    // Delayed match so that a held match only triggers on its first cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_d_r <= 1'b0;
        end else begin
            match_d_r <= match_s;
        end
    end

    // Next-state, snooze count and seconds counter; earlier branches win
    always_comb begin
        state_nxt_s = state_r;
        snz_step_s  = snz_r;
        snz_nxt_s   = snz_r;
        sec_nxt_s   = sec_r;
        if (!alm_en) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (trigger_s) begin
                        state_nxt_s = ST_RING;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RING: begin
                    if (stop_p_s) begin
                        state_nxt_s = ST_IDLE;
                    end else if (snooze_p_s && ({30'd0, snz_r} < MAX_SNOOZE)) begin
                        state_nxt_s = ST_SNOOZE;
                        snz_step_s  = snz_r + 2'd1;
                    end else if (tick_1hz && ({23'd0, sec_r} == RING_SEC - 32'd1)) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_RING;
                    end
                end
                ST_SNOOZE: begin
                    if (stop_p_s) begin
                        state_nxt_s = ST_IDLE;
                    end else if (tick_1hz && ({23'd0, sec_r} == SNOOZE_SEC - 32'd1)) begin
                        state_nxt_s = ST_RING;
                    end else begin
                        state_nxt_s = ST_SNOOZE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end

        // Counter restarts on every state entry and rests at 0 while idle
        if ((state_nxt_s != state_r) || (state_nxt_s == ST_IDLE)) begin
            sec_nxt_s = 9'd0;
        end else if (tick_1hz) begin
            sec_nxt_s = sec_r + 9'd1;
        end else begin
            sec_nxt_s = sec_r;
        end

        if (state_nxt_s == ST_IDLE) begin
            snz_nxt_s = 2'b00;
        end else begin
            snz_nxt_s = snz_step_s;
        end
    end

    // Sequencer registers; start is derived from the next state so it is
    // exactly aligned with state==RING and never glitches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            start_r <= 1'b0;
            snz_r   <= 2'b00;
            sec_r   <= 9'd0;
        end else begin
            state_r <= state_nxt_s;
            start_r <= (state_nxt_s == ST_RING);
            snz_r   <= snz_nxt_s;
            sec_r   <= sec_nxt_s;
        end
    end

    assign start   = start_r;
    assign state   = state_r;
    assign snz_cnt = snz_r;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Self-checking bench for alarm_sequencer with RING_SEC=4, SNOOZE_SEC=3,
// MAX_SNOOZE=2 and a tick every 10 clocks. The reference model counts the
// remaining ticks of each phase down and tracks button history as bit vectors.
module tb_alarm_sequencer;

    localparam int RING = 4;
    localparam int SNZ  = 3;
    localparam int MAXS = 2;
    localparam logic [1:0] M_IDLE = 2'b00;
    localparam logic [1:0] M_RING = 2'b01;
    localparam logic [1:0] M_SNZ  = 2'b10;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       tick_1hz   = 1'b0;
    logic [4:0] cur_hour   = 5'd0;
    logic [5:0] cur_min    = 6'd0;
    logic [5:0] cur_sec    = 6'd0;
    logic [4:0] alm_hour   = 5'd7;
    logic [5:0] alm_min    = 6'd30;
    logic       alm_en     = 1'b0;
    logic       stop_btn   = 1'b0;
    logic       snooze_btn = 1'b0;
    logic       start;
    logic [1:0] state;
    logic [1:0] snz_cnt;

    int n_chk      = 0;
    int n_fail     = 0;
    int tick_phase = 0;

    // reference model state
    logic [1:0] m_state;
    logic [1:0] m_snz;
    logic       m_start;
    int         m_left;
    bit         m_prev_match;
    bit [2:0]   m_stop_h;
    bit [2:0]   m_snz_h;

    alarm_sequencer #(.RING_SEC(RING), .SNOOZE_SEC(SNZ), .MAX_SNOOZE(MAXS)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .alm_hour(alm_hour), .alm_min(alm_min), .alm_en(alm_en),
        .stop_btn(stop_btn), .snooze_btn(snooze_btn),
        .start(start), .state(state), .snz_cnt(snz_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = M_IDLE; m_snz = 2'b00; m_start = 1'b0; m_left = 0;
        m_prev_match = 1'b0; m_stop_h = 3'b000; m_snz_h = 3'b000;
    endtask

    // One clock of behaviour from the current inputs
    task automatic model_step();
        bit stop_p, snz_p, match, trig;
        stop_p = m_stop_h[1] & ~m_stop_h[2];
`ifdef ALARM_SNOOZE_EN
        snz_p = m_snz_h[1] & ~m_snz_h[2];
`else
        snz_p = 1'b0;
`endif
        m_stop_h = {m_stop_h[1:0], stop_btn};
        m_snz_h  = {m_snz_h[1:0], snooze_btn};
        match = alm_en && (cur_hour == alm_hour) && (cur_min == alm_min) && (cur_sec == 6'd0);
        trig = match && !m_prev_match;
        m_prev_match = match;
        if (!alm_en) begin
            m_state = M_IDLE;
        end else if (m_state == M_IDLE) begin
            if (trig) begin m_state = M_RING; m_left = RING; end
        end else if (m_state == M_RING) begin
            if (stop_p) m_state = M_IDLE;
            else if (snz_p && (m_snz < MAXS)) begin
                m_state = M_SNZ; m_snz = m_snz + 2'd1; m_left = SNZ;
            end else if (tick_1hz) begin
                m_left--;
                if (m_left == 0) m_state = M_IDLE;
            end
        end else begin
            if (stop_p) m_state = M_IDLE;
            else if (tick_1hz) begin
                m_left--;
                if (m_left == 0) begin m_state = M_RING; m_left = RING; end
            end
        end
        if (m_state == M_IDLE) m_snz = 2'b00;
        m_start = (m_state == M_RING);
    endtask

    task automatic cycle();
        tick_1hz = (tick_phase == 9);
        model_step();
        @(posedge clk);
        #1;
        tick_phase = (tick_phase + 1) % 10;
    endtask

    task automatic fire_alarm();
        alm_en = 1'b1; cur_hour = 5'd7; cur_min = 6'd30; cur_sec = 6'd1;
        cycle();
        cur_sec = 6'd0;
        cycle();
        cur_sec = 6'd1;
    endtask

    task automatic go_idle();
        stop_btn = 1'b0; snooze_btn = 1'b0; alm_en = 1'b0;
        repeat (4) cycle();
        alm_en = 1'b1; cur_sec = 6'd1;
        cycle();
    endtask

    task automatic press_snooze(input int len);
        snooze_btn = 1'b1;
        repeat (len) cycle();
        snooze_btn = 1'b0;
    endtask

    task automatic test_reset();
        #2; reset = 1'b0; model_reset(); #1;
        n_chk++;
        if ({start, state, snz_cnt} !== 5'b0) begin
            n_fail++; $display("FAIL reset_values: got %b/%b/%b expected 0/00/00", start, state, snz_cnt);
        end
        repeat (3) @(posedge clk);
        #1; reset = 1'b1;
        repeat (3) cycle();
        n_chk++;
        if ({start, state, snz_cnt} !== 5'b0) begin
            n_fail++; $display("FAIL reset_release: got %b/%b/%b expected 0/00/00", start, state, snz_cnt);
        end
    endtask

    task automatic test_basic_ring();
        int nt = 0; bit fell = 1'b0; bit last_tick = 1'b0;
        alm_en = 1'b1; cur_hour = 5'd7; cur_min = 6'd29; cur_sec = 6'd59;
        repeat (3) cycle();
        n_chk++;
        if (state !== M_IDLE) begin n_fail++; $display("FAIL pre_match_idle: state=%b expected 00", state); end
        cur_min = 6'd30; cur_sec = 6'd0;
        cycle();
        n_chk++;
        if ({start, state} !== 3'b101) begin
            n_fail++; $display("FAIL trigger_latency: got start=%b state=%b expected 1/01", start, state);
        end
        cur_sec = 6'd1;
        for (int k = 0; k < 100 && !fell; k++) begin
            last_tick = (tick_phase == 9);
            if (start && last_tick) nt++;
            cycle();
            n_chk++;
            if ({start, state, snz_cnt} !== {m_start, m_state, m_snz}) begin
                n_fail++; $display("FAIL ring_model: got %b/%b/%b expected %b/%b/%b", start, state, snz_cnt, m_start, m_state, m_snz);
            end
            if (!start) fell = 1'b1;
        end
        n_chk++;
        if (!fell || nt != RING || !last_tick || state !== M_IDLE) begin
            n_fail++; $display("FAIL ring_length: ticks=%0d fell=%0d state=%b expected %0d ticks, falling after last tick, state 00", nt, fell, state, RING);
        end
    endtask

    task automatic test_stop();
        go_idle();
        fire_alarm();
        repeat (2) cycle();
        stop_btn = 1'b1;
        cycle();
        n_chk++;
        if (start !== 1'b1) begin n_fail++; $display("FAIL stop_n1: start=%b expected 1", start); end
        cycle();
        n_chk++;
        if (start !== 1'b1) begin n_fail++; $display("FAIL stop_n2: start=%b expected 1", start); end
        cycle();
        n_chk++;
        if ({start, state} !== 3'b000) begin
            n_fail++; $display("FAIL stop_n3: start=%b state=%b expected 0/00", start, state);
        end
        stop_btn = 1'b0;
        for (int s = 1; s < 60; s++) begin
            cur_sec = 6'(s);
            cycle();
        end
        n_chk++;
        if ({start, state, m_state} !== 5'b00000) begin
            n_fail++; $display("FAIL no_retrigger: start=%b state=%b expected 0/00", start, state);
        end
    endtask

`ifdef ALARM_SNOOZE_EN
    task automatic test_snooze_limit();
        bit ok; int nt;
        go_idle();
        fire_alarm();
        repeat (2) cycle();
        for (int r = 1; r <= MAXS; r++) begin
            press_snooze(2);
            ok = 1'b0;
            for (int k = 0; k < 10 && !ok; k++) begin cycle(); if (state == M_SNZ) ok = 1'b1; end
            n_chk++;
            if (!ok || snz_cnt !== 2'(r) || start !== 1'b0) begin
                n_fail++; $display("FAIL snooze_enter%0d: state=%b snz=%b start=%b expected 10/%0d/0", r, state, snz_cnt, start, r);
            end
            ok = 1'b0; nt = 0;
            for (int k = 0; k < 100 && !ok; k++) begin
                if (state == M_SNZ && tick_phase == 9) nt++;
                cycle();
                if (state == M_RING) ok = 1'b1;
            end
            n_chk++;
            if (!ok || nt != SNZ || snz_cnt !== 2'(r) || start !== 1'b1) begin
                n_fail++; $display("FAIL snooze_resume%0d: state=%b ticks=%0d snz=%b start=%b expected 01/%0d/%0d/1", r, state, nt, snz_cnt, start, SNZ, r);
            end
        end
        press_snooze(2);
        repeat (4) cycle();
        n_chk++;
        if ({start, state, snz_cnt} !== {1'b1, M_RING, 2'(MAXS)}) begin
            n_fail++; $display("FAIL snooze_over_limit: got %b/%b/%b expected 1/01/%0d", start, state, snz_cnt, MAXS);
        end
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin cycle(); if (state == M_IDLE) ok = 1'b1; end
        n_chk++;
        if (!ok || start !== 1'b0 || snz_cnt !== 2'b00) begin
            n_fail++; $display("FAIL limit_timeout: state=%b start=%b snz=%b expected 00/0/00", state, start, snz_cnt);
        end
    endtask
`else
    task automatic test_no_snooze();
        go_idle();
        fire_alarm();
        repeat (2) cycle();
        press_snooze(3);
        repeat (5) cycle();
        n_chk++;
        if ({start, state, snz_cnt} !== 5'b10100) begin
            n_fail++; $display("FAIL no_snooze_build: got %b/%b/%b expected 1/01/00", start, state, snz_cnt);
        end
    endtask
`endif

    task automatic test_priority();
        go_idle();
        fire_alarm();
        repeat (2) cycle();
        stop_btn = 1'b1; snooze_btn = 1'b1;
        repeat (3) cycle();
        stop_btn = 1'b0; snooze_btn = 1'b0;
        n_chk++;
        if ({start, state, snz_cnt} !== 5'b00000) begin
            n_fail++; $display("FAIL stop_beats_snooze: got %b/%b/%b expected 0/00/00", start, state, snz_cnt);
        end
        repeat (6) cycle();
        n_chk++;
        if ({start, state, snz_cnt} !== {m_start, m_state, m_snz}) begin
            n_fail++; $display("FAIL priority_settle: got %b/%b/%b expected %b/%b/%b", start, state, snz_cnt, m_start, m_state, m_snz);
        end
    endtask

    task automatic test_disarm_reset();
        go_idle();
        fire_alarm();
        repeat (2) cycle();
`ifdef ALARM_SNOOZE_EN
        press_snooze(2);
        repeat (2) cycle();
        n_chk++;
        if (state !== M_SNZ) begin n_fail++; $display("FAIL disarm_setup: state=%b expected 10", state); end
`endif
        alm_en = 1'b0;
        cycle();
        n_chk++;
        if ({start, state, snz_cnt} !== 5'b00000) begin
            n_fail++; $display("FAIL disarm: got %b/%b/%b expected 0/00/00", start, state, snz_cnt);
        end
        alm_en = 1'b1;
        fire_alarm();
        repeat (3) cycle();
        n_chk++;
        if (start !== 1'b1) begin n_fail++; $display("FAIL reset_setup: start=%b expected 1", start); end
        #2; reset = 1'b0; #1;
        model_reset();
        n_chk++;
        if ({start, state, snz_cnt} !== 5'b00000) begin
            n_fail++; $display("FAIL async_reset: got %b/%b/%b expected 0/00/00", start, state, snz_cnt);
        end
        tick_1hz = 1'b0; cur_sec = 6'd0;
        @(posedge clk); #1;
        cur_sec = 6'd7; reset = 1'b1;
        repeat (5) cycle();
        n_chk++;
        if ({start, state, snz_cnt} !== 5'b00000) begin
            n_fail++; $display("FAIL after_reset: got %b/%b/%b expected 0/00/00", start, state, snz_cnt);
        end
    endtask

    task automatic test_random();
        int stop_hold = 0; int snz_hold = 0;
        go_idle();
        for (int i = 0; i < 3000; i++) begin
            alm_en = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 3) != 0) begin
                cur_hour = 5'd7; cur_min = 6'd30;
            end else begin
                cur_hour = 5'($urandom_range(0, 23)); cur_min = 6'($urandom_range(0, 59));
            end
            cur_sec = 6'($urandom_range(0, 5));
            if (stop_hold > 0) stop_hold--;
            else if ($urandom_range(0, 59) == 0) stop_hold = $urandom_range(1, 4);
            if (snz_hold > 0) snz_hold--;
            else if ($urandom_range(0, 29) == 0) snz_hold = $urandom_range(1, 4);
            stop_btn = (stop_hold > 0);
            snooze_btn = (snz_hold > 0);
            cycle();
            n_chk++;
            if ({start, state, snz_cnt} !== {m_start, m_state, m_snz}) begin
                n_fail++; $display("FAIL random_cycle%0d: got %b/%b/%b expected %b/%b/%b", i, start, state, snz_cnt, m_start, m_state, m_snz);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_ring();
        test_stop();
`ifdef ALARM_SNOOZE_EN
        test_snooze_limit();
`else
        test_no_snooze();
`endif
        test_priority();
        test_disarm_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
